// File: rtl/imem_pkg.sv
// imem_pkg
// Shared definitions for the instruction-memory fetch unit.
//   NOP_WORD    : instruction returned for faulting fetches and after reset
//   BYTE_OFS_W  : byte-offset bits below the word index (word-aligned = all zero)
//   MIN_DEPTH   : smallest supported word count
//   state_t     : LOAD (program download) / RUN (fetch service)
package imem_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam int          BYTE_OFS_W = 2;
    localparam int          MIN_DEPTH  = 4;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// imem_ram
// Word storage for the fetch unit: one write port and one synchronous read port.
// The read register only updates when re is high, so it holds the last fetched
// word while the consumer stalls.
// Ports:
//   clk   : clock, all updates on the rising edge
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   re    : read enable (loads rdata)
//   raddr : read word index
//   rdata : registered read data
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or the read register: program contents must
    // survive a reset of the fetch logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
// Instruction memory with a program-load phase (LOAD) followed by a fetch
// service phase (RUN). Fetches answer one cycle after acceptance through a
// valid/ready response register; misaligned or out-of-range fetches return
// NOP_WORD with rsp_fault set.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   load_en/load_addr/load_data     : program-load write (LOAD only)
//   load_done                       : leave LOAD for RUN
//   load_err                        : one-cycle pulse for a rejected load
//   req_valid/req_addr/req_ready    : fetch request handshake
//   rsp_valid/rsp_instr/rsp_fault   : fetch response, held while !rsp_ready
//   rsp_ready                       : consumer accepts the response
//   mode_run                        : 1 in RUN
//   fetch_cnt                       : accepted-request counter (wraps)
module imem_fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic              load_err,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    input  logic              rsp_ready,
    output logic              mode_run,
    output logic [31:0]       fetch_cnt
);

    import imem_pkg::*;

    localparam int IDX_W  = $clog2(DEPTH);
    // First address bit above the word index; anything set from here up is
    // beyond the array.
    localparam int IDX_HI = IDX_W + BYTE_OFS_W;

    state_t            state;
    logic              load_fault;
    logic              fetch_fault;
    logic              accept;
    logic              ram_we;
    logic              ram_re;
    logic              use_ram;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  fetch_idx;
    logic [DATA_W-1:0] ram_rdata;

    assign load_idx    = load_addr[IDX_HI-1:BYTE_OFS_W];
    assign fetch_idx   = req_addr[IDX_HI-1:BYTE_OFS_W];
    assign load_fault  = (load_addr[BYTE_OFS_W-1:0] != '0) || (load_addr[ADDR_W-1:IDX_HI] != '0);
    assign fetch_fault = (req_addr[BYTE_OFS_W-1:0] != '0) || (req_addr[ADDR_W-1:IDX_HI] != '0);

    assign ram_we    = load_en && (state == LOAD) && !load_fault;
    assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign ram_re    = accept && !fetch_fault;

    // The RAM read register carries good data; use_ram selects it, otherwise
    // the response is the NOP filler (faults and the post-reset value).
    assign rsp_instr = use_ram ? ram_rdata : NOP_WORD;

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_idx),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

    // Mode FSM. A load on the same edge as load_done still writes because
    // ram_we is qualified with the current (LOAD) state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            mode_run <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_en && ((state == RUN) || load_fault);
            if ((state == LOAD) && load_done) begin
                state    <= RUN;
                mode_run <= 1'b1;
            end
        end
    end

    // Response register. A new accept overrides the handshake clear so that
    // back-to-back fetches stream one per cycle. Reset drops any in-flight
    // response so it is never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            use_ram   <= 1'b0;
            fetch_cnt <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fetch_fault;
            use_ram   <= !fetch_fault;
            fetch_cnt <= fetch_cnt + 32'd1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit
// Scoreboard bench for imem_fetch_unit: accepted fetches push the expected
// response computed from a word-array reference model; a negedge monitor
// pops and compares whenever the DUT presents a response.
module tb_imem_fetch_unit;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_done = 1'b0;
    logic        load_err;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        rsp_ready = 1'b0;
    logic        mode_run;
    logic [31:0] fetch_cnt;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_done (load_done),
        .load_err  (load_err),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .rsp_ready (rsp_ready),
        .mode_run  (mode_run),
        .fetch_cnt (fetch_cnt)
    );

    int          checks = 0;
    int          fails = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] prog [4] = '{32'hFFC4A303, 32'h0064A423, 32'h0062E233, 32'hFE420AE3};
    rsp_t        exp_q [$];
    bit          exp_run = 1'b0;
    logic [31:0] exp_cnt = '0;
    logic [31:0] cnt_offset = '0;
    bit          pending = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference fetch: aligned in-range addresses read the model array,
    // everything else is a NOP fault.
    function automatic rsp_t modelFetch(input logic [31:0] addr);
        rsp_t r;
        if ((addr % 4 != 0) || (addr / 4 >= DEPTH)) begin
            r.instr = NOP;
            r.fault = 1'b1;
        end else begin
            r.instr = ref_mem[addr / 4];
            r.fault = 1'b0;
        end
        return r;
    endfunction

    // Drive one cycle of fetch-side inputs; called and returns at posedge+1.
    task automatic applyStimulus(input bit v, input logic [31:0] a, input bit rdy);
        req_valid = v;
        req_addr  = a;
        rsp_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // One load cycle; the model decides whether it is legal and checks load_err.
    task automatic applyLoad(input logic [31:0] a, input logic [31:0] d, input bit done);
        bit bad;
        bad       = exp_run || (a % 4 != 0) || (a / 4 >= DEPTH);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        load_done = done;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
        load_done = 1'b0;
        if (!bad) ref_mem[a / 4] = d;
        if (done) exp_run = 1'b1;
        checkOutput("load_err", 32'(load_err), 32'(bad));
    endtask

    // Monitor/scoreboard: compare the presented response, then record any
    // accept happening on the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pending = 1'b0;
            exp_cnt = '0;
        end else begin
            if (pending) checkOutput("rsp_latency", 32'(rsp_valid), 32'd1);
            pending = 1'b0;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 instr=%h, expected no response at %0t", rsp_instr, $time);
                end else begin
                    checkOutput("rsp_instr", rsp_instr, exp_q[0].instr);
                    checkOutput("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].fault));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            checkOutput("req_ready", 32'(req_ready), 32'(exp_run && (!rsp_valid || rsp_ready)));
            checkOutput("mode_run", 32'(mode_run), 32'(exp_run));
            checkOutput("fetch_cnt", fetch_cnt, exp_cnt + cnt_offset);
            if (req_valid && req_ready) begin
                exp_q.push_back(modelFetch(req_addr));
                exp_cnt = exp_cnt + 32'd1;
                pending = 1'b1;
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_instr", rsp_instr, NOP);
        checkOutput("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        checkOutput("rst_mode_run", 32'(mode_run), 32'd0);
        checkOutput("rst_load_err", 32'(load_err), 32'd0);
        checkOutput("rst_fetch_cnt", fetch_cnt, 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Program load: directed words first, random fill for the rest
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyLoad(32'(i * 4), (i < 4) ? prog[i] : $urandom, 1'b0);
        end

        // Rejected loads in LOAD: misaligned and one word past the end
        applyLoad(32'h0000_0002, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("load_err_pulse_misaligned", 32'(load_err), 32'd0);
        applyLoad(32'(DEPTH * 4), 32'hBAD0_0400, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("load_err_pulse_range", 32'(load_err), 32'd0);

        // Last word written on the same edge that enters RUN
        applyLoad(32'((DEPTH - 1) * 4), 32'hA5A5_5A5A, 1'b1);

        // Back-to-back fetch of the directed program
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("fetch_cnt_after_4", fetch_cnt, 32'd4);

        // Fault responses: misaligned and out of range
        applyStimulus(1'b1, 32'h0000_0016, 1'b1);
        checkOutput("fault_misaligned_instr", rsp_instr, NOP);
        applyStimulus(1'b1, 32'(DEPTH * 4), 1'b1);
        checkOutput("fault_range_fault", 32'(rsp_fault), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Stall: response held for three cycles, then one handshake
        applyStimulus(1'b1, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_instr", rsp_instr, 32'h0064A423);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            applyStimulus(1'b1, 32'h0000_0008, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("stall_released", 32'(rsp_valid), 32'd0);

        // Load attempt in RUN is rejected and leaves memory alone
        applyLoad(32'h0000_0000, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("load_err_pulse_run", 32'(load_err), 32'd0);
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        checkOutput("mem_unchanged_word0", rsp_instr, 32'hFFC4A303);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Randomized traffic
        repeat (400) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (r == 7) a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            else             a = $urandom | 32'h0000_0400;
            applyStimulus($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset in the middle of a stalled response
        applyStimulus(1'b1, 32'h0000_0008, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        #2;
        rst_n   = 1'b0;
        exp_run = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_mode_run", 32'(mode_run), 32'd0);
        checkOutput("midrst_rsp_instr", rsp_instr, NOP);
        checkOutput("midrst_fetch_cnt", fetch_cnt, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        load_done = 1'b1;
        @(posedge clk);
        #1;
        load_done = 1'b0;
        exp_run   = 1'b1;
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        checkOutput("post_reset_fetch0", rsp_instr, 32'hFFC4A303);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Counter wrap from all-ones
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        cnt_offset = 32'hFFFF_FFFF - exp_cnt;
        #1;
        release dut.fetch_cnt;
        applyStimulus(1'b1, 32'h0000_000C, 1'b1);
        checkOutput("fetch_cnt_wrap", fetch_cnt, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32, instruction width in bits.
- DEPTH, 256, number of words (power of two, at least 4).
- ADDR_W, 32, byte-address width.
- NOP_WORD, 32'h00000013, word returned on fault.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  program-load byte address.
- load_data  in  DATA_W  program-load word.
- load_done  in  1  ends LOAD mode.
- load_err  out  1  one-cycle pulse: rejected load.
- req_valid  in  1  fetch request valid.
- req_addr  in  ADDR_W  fetch byte address (PC).
- req_ready  out  1  fetch request accepted.
- rsp_valid  out  1  response valid.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_fault  out  1  response is a fault (misaligned or out of range).
- rsp_ready  in  1  consumer accepts response.
- mode_run  out  1  1 in RUN, 0 in LOAD.
- fetch_cnt  out  32  count of accepted fetch requests.

Function
REQ-003 FSM SHALL have two states, LOAD and RUN; reset enters LOAD; LOAD->RUN when load_done=1; RUN is left only by reset.
REQ-004 In LOAD, load_en=1 SHALL write load_data to word load_addr[log2(DEPTH)+1:2] at the clock edge.
REQ-005 A load with load_addr[1:0]!=0 or word index >= DEPTH SHALL NOT write and SHALL pulse load_err the next cycle.
REQ-006 load_en in RUN SHALL NOT write and SHALL pulse load_err the next cycle.
REQ-007 If load_en and load_done are both 1 in LOAD, the write SHALL occur and RUN SHALL be entered on the same edge.
REQ-008 req_ready SHALL be 0 in LOAD; in RUN, req_ready SHALL be (!rsp_valid || rsp_ready), combinationally.
REQ-009 A request is accepted when req_valid && req_ready at an edge; rsp_valid SHALL be 1 the following cycle (latency exactly 1).
REQ-010 An accepted aligned, in-range request SHALL give rsp_instr = mem[word index] and rsp_fault = 0.
REQ-011 An accepted request with req_addr[1:0]!=0 or word index >= DEPTH SHALL give rsp_instr = NOP_WORD and rsp_fault = 1.
REQ-012 While rsp_valid && !rsp_ready, rsp_valid, rsp_instr and rsp_fault SHALL hold stable.
REQ-013 rsp_valid SHALL clear after a handshake with no new accept on the same edge; with a new accept on the same edge it SHALL remain 1 carrying the new data (full throughput, one per cycle).
REQ-014 fetch_cnt SHALL increment by 1 per accepted request and wrap from 32'hFFFFFFFF to 0.
REQ-015 Word storage SHALL be a synchronous-read array; the output register SHALL load only on accept.

Reset
REQ-016 On rst_n=0, asynchronously and regardless of state:
- state = LOAD, mode_run = 0
- rsp_valid = 0, rsp_instr = NOP_WORD, rsp_fault = 0
- load_err = 0, fetch_cnt = 0
REQ-017 Reset SHALL NOT clear memory contents.
REQ-018 An in-flight response lost to reset mid-operation SHALL never be presented.

Structure
REQ-019 NOP_WORD, the state encoding typedef (LOAD/RUN) and the address-check width constants SHALL live in shared package imem_pkg.
REQ-020 The word array SHALL be one sub-module, imem_ram (1 write port, 1 synchronous read port, parameters DATA_W and DEPTH).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load 32'hFFC4A303@0x0, 32'h0064A423@0x4, 32'h0062E233@0x8, 32'hFE420AE3@0xC, then load_done; fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> 4 consecutive rsp_valid cycles with those words, rsp_fault=0, fetch_cnt=4.
- RUN, req_addr=0x16 -> rsp_fault=1, rsp_instr=32'h00000013; req_addr=DEPTH*4 -> same fault response.
- Fetch 0x4 with rsp_ready=0 for 3 cycles -> rsp_instr=32'h0064A423 held stable, req_ready=0, then one handshake when rsp_ready=1.
- load_en with load_addr=0x2 in LOAD, and load_en in RUN -> load_err pulses once each, and a later read shows memory unchanged.
- rst_n asserted mid-stall with rsp_valid=1 -> rsp_valid=0 and mode_run=0 immediately; after load_done, fetch 0x0 returns 32'hFFC4A303.
- fetch_cnt preloaded via force to 32'hFFFFFFFF, one accept -> fetch_cnt=0.
